// File: rtl/bcd_pkg.sv
// Shared types and segment constants for the BCD display scanner.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package bcd_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h00;
    localparam seg7_t SEG_DASH  = 7'h40;

    localparam seg7_t SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder (active-high segments).
// Codes above 9 are shown as a dash.
module bcd_to_seg7
    import bcd_pkg::*;
(
    input  logic [3:0] bcd_i,
    output seg7_t      seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (bcd_i <= 4'd9) begin
            seg_o = SEG_DIGIT[bcd_i];
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed 7-segment scanner: snapshots packed BCD digits once per frame and
// drives one digit per slot, with a guard interval and leading-zero blanking.
module bcd_display_scanner
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int GUARD_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LZ       = 1'b1,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IW-1:0]           digit_idx,
    output logic                    frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] LAST_P   = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GUARD    = PW'(GUARD_CYCLES);
    localparam seg7_t                 SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

    scan_state_t             state_q, state_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    seg7_t                   seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    frame_end;
    logic                    lz_blank;
    logic [3:0]              cur_digit;
    seg7_t                   dec_seg;
    seg7_t                   seg_raw;
    logic [NUM_DIGITS-1:0]   an_raw;

    assign frame_end = (state_q != IDLE) && (presc_q == LAST_P) && (idx_q == LAST_IDX);
    assign cur_digit = shadow_q[{idx_q, 2'b00} +: 4];
    // Digit i>0 is a leading zero when it and every digit above it are zero.
    assign lz_blank  = BLANK_LZ && (idx_q != '0) && ((shadow_q >> {idx_q, 2'b00}) == '0);

    bcd_to_seg7 u_dec (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        if (!enable) begin
            state_d = IDLE;
            presc_d = '0;
            idx_d   = '0;
        end else begin
            if (state_q == IDLE) begin
                presc_d  = '0;
                idx_d    = '0;
                shadow_d = digits;
            end else if (presc_q == LAST_P) begin
                presc_d = '0;
                if (frame_end) begin
                    idx_d    = '0;
                    shadow_d = digits;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
            // Guard phase is derived from the next prescaler value; GUARD=0 skips BLANK.
            state_d = (presc_d < GUARD) ? BLANK : SHOW;
        end
    end

    always_comb begin
        seg_raw = SEG_BLANK;
        an_raw  = '0;
        if (state_q == SHOW && !lz_blank) begin
            seg_raw = dec_seg;
            an_raw  = NUM_DIGITS'(1) << idx_q;
        end
        seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        an_d  = AN_ACTIVE_LOW  ? ~an_raw  : an_raw;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            seg_q    <= SEG_OFF;
            an_q     <= AN_OFF;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_tick = frame_end;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench: an active-high and an active-low scanner share stimulus; the
// active-low copy must always show the bitwise inverse with identical timing.
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] digits;

    logic [6:0]  seg_h, seg_l;
    logic [3:0]  an_h, an_l;
    logic [1:0]  idx_h, idx_l;
    logic        ft_h, ft_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_display_scanner #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (4),
        .GUARD_CYCLES   (1),
        .SEG_ACTIVE_LOW (1'b0),
        .AN_ACTIVE_LOW  (1'b0),
        .BLANK_LZ       (1'b1)
    ) u_hi (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digits     (digits),
        .seg        (seg_h),
        .an         (an_h),
        .digit_idx  (idx_h),
        .frame_tick (ft_h)
    );

    bcd_display_scanner #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (4),
        .GUARD_CYCLES   (1),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1),
        .BLANK_LZ       (1'b1)
    ) u_lo (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digits     (digits),
        .seg        (seg_l),
        .an         (an_l),
        .digit_idx  (idx_l),
        .frame_tick (ft_l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [6:0] es, input logic [3:0] ea);
        check({tag, " seg"},    {1'b0, seg_h}, {1'b0, es});
        check({tag, " an"},     {4'h0, an_h},  {4'h0, ea});
        check({tag, " seg_lo"}, {1'b0, seg_l}, {1'b0, ~es});
        check({tag, " an_lo"},  {4'h0, an_l},  {4'h0, ~ea});
    endtask

    task automatic check_ctl(input string tag, input logic [1:0] ei, input logic ef);
        check({tag, " idx"},    {6'h0, idx_h}, {6'h0, ei});
        check({tag, " idx_lo"}, {6'h0, idx_l}, {6'h0, ei});
        check({tag, " ftick"},  {7'h0, ft_h},  {7'h0, ef});
        check({tag, " ftick_lo"}, {7'h0, ft_l}, {7'h0, ef});
    endtask

    // Entered on the slot's first (guard) cycle; returns on the next slot's first cycle.
    task automatic check_slot(input string tag, input logic [1:0] idx,
                              input logic [6:0] es, input logic [3:0] ea);
        check_ctl({tag, " p0"}, idx, 1'b0);
        tick();
        check_ctl({tag, " p1"}, idx, 1'b0);
        check_out({tag, " guard"}, 7'h00, 4'h0);
        tick();
        check_out({tag, " p2"}, es, ea);
        tick();
        check_ctl({tag, " p3"}, idx, idx == 2'd3);
        check_out({tag, " p3"}, es, ea);
        tick();
        check_out({tag, " tail"}, es, ea);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        digits = 16'h0000;
        repeat (3) tick();
        check_out("reset", 7'h00, 4'h0);
        check_ctl("reset", 2'd0, 1'b0);

        // Frame 1: 0907, with a mid-frame input change that must not tear.
        reset  = 1'b0;
        enable = 1'b1;
        digits = 16'h0907;
        tick();
        check_out("start", 7'h00, 4'h0);
        check_slot("f1d0", 2'd0, 7'h07, 4'b0001);
        check_slot("f1d1", 2'd1, 7'h3F, 4'b0010);
        digits = 16'h1234;
        check_slot("f1d2", 2'd2, 7'h6F, 4'b0100);
        check_slot("f1d3", 2'd3, 7'h00, 4'b0000);

        // Frame 2: snapshot taken at the frame boundary.
        check_slot("f2d0", 2'd0, 7'h66, 4'b0001);
        digits = 16'h0000;
        check_slot("f2d1", 2'd1, 7'h4F, 4'b0010);
        check_slot("f2d2", 2'd2, 7'h5B, 4'b0100);
        check_slot("f2d3", 2'd3, 7'h06, 4'b1000);

        // Frame 3: all zero, only digit 0 lit.
        check_slot("f3d0", 2'd0, 7'h3F, 4'b0001);
        digits = 16'h00A0;
        check_slot("f3d1", 2'd1, 7'h00, 4'b0000);
        check_slot("f3d2", 2'd2, 7'h00, 4'b0000);
        check_slot("f3d3", 2'd3, 7'h00, 4'b0000);

        // Frame 4: invalid code counts as nonzero and shows a dash.
        check_slot("f4d0", 2'd0, 7'h3F, 4'b0001);
        digits = 16'h0456;
        check_slot("f4d1", 2'd1, 7'h40, 4'b0010);
        check_slot("f4d2", 2'd2, 7'h00, 4'b0000);
        check_slot("f4d3", 2'd3, 7'h00, 4'b0000);

        // Frame 5: drop enable during slot 2.
        check_slot("f5d0", 2'd0, 7'h7D, 4'b0001);
        check_slot("f5d1", 2'd1, 7'h6D, 4'b0010);
        tick();
        tick();
        check_out("f5d2", 7'h66, 4'b0100);
        enable = 1'b0;
        tick();
        check_ctl("dis1", 2'd0, 1'b0);
        check_out("dis1", 7'h66, 4'b0100);
        tick();
        check_out("dis2", 7'h00, 4'h0);
        tick();
        check_out("dis3", 7'h00, 4'h0);
        check_ctl("dis3", 2'd0, 1'b0);

        // Re-enable: fresh snapshot, restart at digit 0.
        digits = 16'h0018;
        enable = 1'b1;
        tick();
        check_slot("re0", 2'd0, 7'h7F, 4'b0001);
        tick();
        tick();
        check_out("re1", 7'h06, 4'b0010);

        // Synchronous reset mid-SHOW with enable held high.
        reset = 1'b1;
        tick();
        check_out("rst", 7'h00, 4'h0);
        check_ctl("rst", 2'd0, 1'b0);
        reset  = 1'b0;
        digits = 16'h0023;
        tick();
        check_out("post", 7'h00, 4'h0);
        check_slot("p0", 2'd0, 7'h4F, 4'b0001);
        check_slot("p1", 2'd1, 7'h5B, 4'b0010);
        check_slot("p2", 2'd2, 7'h00, 4'b0000);
        check_slot("p3", 2'd3, 7'h00, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
